// File: rtl/alu_op_sequencer_if.sv
// Bus bundle for alu_op_sequencer: command handshake, ALU-unit drive/return and result handshake.
// Modport master is the sequencer side; slave is the environment (command source, units, consumer).
interface alu_op_sequencer_if #(
  parameter int Op_Width = 16
);
  logic                Cmd_Valid;
  logic                Cmd_Ready;
  logic [Op_Width-1:0] Cmd_A;
  logic [Op_Width-1:0] Cmd_B;
  logic [3:0]          Cmd_Fun;
  logic [Op_Width-1:0] A;
  logic [Op_Width-1:0] B;
  logic [1:0]          ALU_FUN;
  logic                Arith_En;
  logic                Logic_En;
  logic                CMP_En;
  logic                Shift_En;
  logic [Op_Width-1:0] Unit_Out;
  logic                Unit_Flag;
  logic                Res_Valid;
  logic                Res_Ready;
  logic [Op_Width-1:0] Res_Data;
  logic                Res_Err;

  modport master (
    input  Cmd_Valid, Cmd_A, Cmd_B, Cmd_Fun, Unit_Out, Unit_Flag, Res_Ready,
    output Cmd_Ready, A, B, ALU_FUN, Arith_En, Logic_En, CMP_En, Shift_En,
           Res_Valid, Res_Data, Res_Err
  );

  modport slave (
    output Cmd_Valid, Cmd_A, Cmd_B, Cmd_Fun, Unit_Out, Unit_Flag, Res_Ready,
    input  Cmd_Ready, A, B, ALU_FUN, Arith_En, Logic_En, CMP_En, Shift_En,
           Res_Valid, Res_Data, Res_Err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Single-command ALU sequencer: IDLE -> ISSUE (one unit enable) -> WAIT (unit result) -> HOLD (handoff).
// Optional WAIT timeout is compiled in with `define ALU_SEQ_TIMEOUT_EN (limit TIMEOUT_CYC).
module alu_op_sequencer #(
  parameter int Op_Width    = 16,
  parameter int TIMEOUT_CYC = 4
) (
  input logic                CLK,
  input logic                RST,
  alu_op_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t              state_q, state_d;
  logic [Op_Width-1:0] a_q, b_q, res_data_q;
  logic [1:0]          fun_q, sel_q;
  logic                accept, capture;

  if (TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("TIMEOUT_CYC must be at least 1");
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] tmo_cnt_q;
  logic            tmo_hit, tmo_fire, res_err_q;

  // Hit on the WAIT cycle whose increment would reach the limit: exactly TIMEOUT_CYC WAIT cycles.
  assign tmo_hit = (tmo_cnt_q + CntW'(1)) == CntW'(TIMEOUT_CYC);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                       tmo_cnt_q <= '0;
    else if (state_q == ISSUE)                     tmo_cnt_q <= '0;
    else if ((state_q == WAIT) && !bus.Unit_Flag)  tmo_cnt_q <= tmo_cnt_q + CntW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           res_err_q <= 1'b0;
    else if (capture)  res_err_q <= 1'b0;
    else if (tmo_fire) res_err_q <= 1'b1;
  end

  assign bus.Res_Err = res_err_q;
`else
  assign bus.Res_Err = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
    tmo_fire = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Cmd_Valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // A unit result on the limit cycle wins over the timeout.
        if (bus.Unit_Flag) begin
          capture = 1'b1;
          state_d = HOLD;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = HOLD;
        end
`endif
      end
      HOLD: begin
        if (bus.Res_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      sel_q      <= '0;
      res_data_q <= '0;
    end else begin
      if (accept) begin
        a_q   <= bus.Cmd_A;
        b_q   <= bus.Cmd_B;
        fun_q <= bus.Cmd_Fun[1:0];
        sel_q <= bus.Cmd_Fun[3:2];
      end
      if (capture) res_data_q <= bus.Unit_Out;
`ifdef ALU_SEQ_TIMEOUT_EN
      else if (tmo_fire) res_data_q <= '0;
`endif
    end
  end

  assign bus.Cmd_Ready = (state_q == IDLE);
  assign bus.Res_Valid = (state_q == HOLD);
  assign bus.Res_Data  = res_data_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.ALU_FUN   = fun_q;
  assign bus.Arith_En  = (state_q == ISSUE) && (sel_q == 2'b00);
  assign bus.Logic_En  = (state_q == ISSUE) && (sel_q == 2'b01);
  assign bus.CMP_En    = (state_q == ISSUE) && (sel_q == 2'b10);
  assign bus.Shift_En  = (state_q == ISSUE) && (sel_q == 2'b11);

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter Op_Width, default 16: operand and result width.
REQ-002 Parameter TIMEOUT_CYC, default 4: WAIT-cycle limit, used only when the Configuration feature is compiled in.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 Cmd_Valid  input  1  command offered.
REQ-006 Cmd_Ready  output  1  sequencer can accept a command.
REQ-007 Cmd_A, Cmd_B  input  Op_Width  command operands.
REQ-008 Cmd_Fun  input  4  bits [3:2] select the unit (00 arith, 01 logic, 10 cmp, 11 shift); bits [1:0] are the unit function code.
REQ-009 A, B  output  Op_Width  operands driven to the ALU units.
REQ-010 ALU_FUN  output  2  function code driven to the ALU units.
REQ-011 Arith_En, Logic_En, CMP_En, Shift_En  output  1 each  unit enables.
REQ-012 Unit_Out  input  Op_Width  muxed registered result from the units.
REQ-013 Unit_Flag  input  1  muxed registered result-valid flag from the units.
REQ-014 Res_Valid  output  1  result available.
REQ-015 Res_Ready  input  1  consumer accepts the result.
REQ-016 Res_Data  output  Op_Width  captured result.
REQ-017 Res_Err  output  1  timeout error marker for the current result.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT and HOLD, and all outputs SHALL be registered or decoded from the state register only.
REQ-019 In IDLE, Cmd_Ready SHALL be 1; in every other state it SHALL be 0.
REQ-020 In IDLE with Cmd_Valid=1, the sequencer SHALL capture Cmd_A/Cmd_B/Cmd_Fun into A/B/ALU_FUN and the unit select on that edge, then go to ISSUE.
REQ-021 In ISSUE, exactly one enable (chosen by Cmd_Fun[3:2]) SHALL be 1 for exactly one cycle, and the FSM SHALL go unconditionally to WAIT.
REQ-022 In WAIT, all enables SHALL be 0.
REQ-023 In WAIT with Unit_Flag=1, the sequencer SHALL capture Unit_Out into Res_Data, clear Res_Err, and go to HOLD.
REQ-024 Unit_Flag and Unit_Out SHALL be ignored in IDLE, ISSUE and HOLD.
REQ-025 In HOLD, Res_Valid SHALL be 1 and Res_Data/Res_Err SHALL be stable.
REQ-026 In HOLD with Res_Ready=1, the FSM SHALL go to IDLE and Res_Valid SHALL be 0 on the next cycle.
REQ-027 Res_Ready held at 1 in advance SHALL complete the handoff on the first HOLD cycle.
REQ-028 Latency SHALL be fixed: command accepted at edge k -> ISSUE cycle k+1, WAIT cycle k+2, Res_Valid=1 from cycle k+3 when the unit responds in one cycle.
REQ-029 Peak throughput SHALL be one command per 4 cycles.
REQ-030 Cmd_Valid while Cmd_Ready=0 SHALL be ignored with no capture and no state change.
REQ-031 A, B and ALU_FUN SHALL hold their values from capture until the next accepted command.
REQ-032 Without the Configuration feature, WAIT SHALL persist indefinitely until Unit_Flag=1.

Reset
REQ-033 RST=1 SHALL asynchronously force state IDLE and all outputs to 0 (A, B, ALU_FUN, all enables, Res_Valid, Res_Data, Res_Err, timeout counter), except Cmd_Ready, which SHALL be 1.
REQ-034 Reset asserted mid-operation SHALL discard the in-flight command and any held result, with no Res_Valid pulse after release.
REQ-035 After RST deasserts, the first command SHALL be accepted on the first rising edge.

Configuration
REQ-036 Macro ALU_SEQ_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT and increment on each WAIT cycle with Unit_Flag=0.
REQ-037 With ALU_SEQ_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYC, the sequencer SHALL set Res_Data=0 and Res_Err=1 and go to HOLD.
REQ-038 With ALU_SEQ_TIMEOUT_EN defined, a Unit_Flag arriving on that same cycle SHALL take priority (normal capture, Res_Err=0).
REQ-039 Macro ALU_SEQ_TIMEOUT_EN undefined: no counter SHALL be instantiated and Res_Err SHALL be tied to 0.

Verification
REQ-040 Logic AND: Cmd_Fun=4'b0100, A=16'h00FF, B=16'h0F0F, accepted at edge k, unit model responding 1 cycle after its enable -> Logic_En=1 only in cycle k+1, Res_Valid=1 at k+3, Res_Data=16'h000F.
REQ-041 Backpressure: Res_Ready=0 for 5 cycles in HOLD -> Res_Valid and Res_Data constant, Cmd_Ready=0 throughout; Res_Ready=1 -> IDLE next cycle.
REQ-042 Busy: new Cmd_Valid with A=16'h1234 during WAIT -> ignored, A unchanged, exactly one result produced.
REQ-043 Reset mid-op: RST=1 during WAIT -> immediate IDLE, Cmd_Ready=1, Res_Valid=0; a late Unit_Flag=1 after release is not captured.
REQ-044 Enable decode: Cmd_Fun[3:2]=00/10/11 -> only Arith_En/CMP_En/Shift_En respectively pulses for one cycle.
REQ-045 Timeout (ALU_SEQ_TIMEOUT_EN defined, TIMEOUT_CYC=4): Unit_Flag held at 0 -> Res_Valid=1 with Res_Err=1 and Res_Data=0 after 4 WAIT cycles; with the macro undefined, the sequencer stays in WAIT.
